// File: rtl/packer_pkg.sv
// Shared types for the buffer write-side packer: FSM state encoding, the default
// word type and a helper that maps a lane number to its bit offset in the packed bus.
package packer_pkg;

    typedef enum logic {FILL, ISSUE} packer_state_t;

    localparam int WORD_BITS = 16;
    typedef logic [WORD_BITS-1:0] word_t;

    function automatic int lane_lo(input int lane, input int size);
        return lane * size;
    endfunction

endpackage

// File: rtl/buffer_packer.sv
// Packs PAR_WRITE consecutive SIZE-bit words into one wide buffer write (word 0 in lane 0).
// Optional partial-pack flush with PAD_VALUE fill is enabled by defining PACKER_FLUSH_EN.
module buffer_packer
    import packer_pkg::*;
#(
    parameter int              SIZE      = 16,
    parameter int              PAR_WRITE = 4,
    parameter logic [SIZE-1:0] PAD_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [SIZE-1:0]                in_data,
    output logic                           in_ready,
    input  logic                           flush,
    input  logic                           buf_ready,
    output logic                           buf_wen,
    output logic [PAR_WRITE*SIZE-1:0]      buf_din,
    output logic [$clog2(PAR_WRITE+1)-1:0] pending
);

    localparam int CW = $clog2(PAR_WRITE + 1);
    localparam logic [CW-1:0] LAST = CW'(PAR_WRITE - 1);

    packer_state_t             state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [PAR_WRITE*SIZE-1:0] lanes_q, lanes_d;

    // Handshake: a word moves when in_valid & in_ready; a pack moves when buf_wen,
    // which is only raised while buf_ready is high. Both are sampled at the rising edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lanes_d  = lanes_q;
        in_ready = 1'b0;
        buf_wen  = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    lanes_d[lane_lo(int'(cnt_q), SIZE) +: SIZE] = in_data;
                    cnt_d = cnt_q + CW'(1);
                end
                if (in_valid && cnt_q == LAST) begin
                    state_d = ISSUE;
                end
`ifdef PACKER_FLUSH_EN
                // The same-cycle word is already in lanes_d, so padding starts after it.
                else if (flush && cnt_d != '0) begin
                    for (int i = 0; i < PAR_WRITE; i++) begin
                        if (i >= int'(cnt_d)) begin
                            lanes_d[lane_lo(i, SIZE) +: SIZE] = PAD_VALUE;
                        end
                    end
                    state_d = ISSUE;
                end
`endif
            end
            ISSUE: begin
                in_ready = buf_ready;
                buf_wen  = buf_ready;
                if (buf_ready) begin
                    state_d = FILL;
                    if (in_valid) begin
                        lanes_d[lane_lo(0, SIZE) +: SIZE] = in_data;
                        cnt_d = CW'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

`ifndef PACKER_FLUSH_EN
    logic [SIZE:0] flush_unused;
    assign flush_unused = {flush, PAD_VALUE};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            lanes_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lanes_q <= lanes_d;
        end
    end

    assign buf_din = lanes_q;
    assign pending = cnt_q;

endmodule
